pipelined_adder_sat: RTL and testbench
======================================

// Module: pipelined_adder_sat
// PURPOSE
// - Parametrised, pipelined successor of the team's 1-bit full adder: WIDTH-bit add/subtract
//   split into STAGES carry-segmented slices, one registered slice per cycle.
// - Sits in the image-filter datapath (pixel/kernel accumulation); optional unsigned saturation
//   clamps results to the pixel range. valid/ready stream handshake on both sides.
// PARAMETERS
// - WIDTH     8  operand/result width in bits; must be a multiple of STAGES
// - STAGES    2  pipeline depth = number of carry segments (1..WIDTH); SEG = WIDTH/STAGES
// - SATURATE  1  1: clamp unsigned result on overflow/underflow; 0: wrap modulo 2^WIDTH
// PORTS
// - clk        in   1      clock, all state on rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - in_valid   in   1      operand beat valid
// - in_ready   out  1      block accepts beat this cycle
// - in_a       in   WIDTH  operand A (unsigned)
// - in_b       in   WIDTH  operand B (unsigned)
// - in_sub     in   1      0: A+B, 1: A-B (two's complement: ~B, carry-in 1)
// - out_valid  out  1      result beat valid
// - out_ready  in   1      downstream accepts result
// - out_sum    out  WIDTH  result (saturated if SATURATE=1)
// - out_cout   out  1      raw MSB carry; add: 1 = overflow, sub: 0 = borrow
// - out_sat    out  1      1 when a clamp was applied (always 0 if SATURATE=0)
// BEHAVIOUR
// - Reset (rst_n=0, async): all stage valid bits, out_valid, out_sum, out_cout, out_sat -> 0;
//   in-flight beats discarded. in_ready is combinational and reads 1 out of reset.
// - advance = ~out_valid | out_ready; in_ready = advance. Whole pipeline shifts only on advance;
//   on stall every stage register (data, carry, valid) holds. Bubbles are not compressed.
// - Input beat captured when in_valid & in_ready; stage valid bits carry it forward.
// - Stage k (0..STAGES-1) adds slice [k*SEG +: SEG] of A and B' (B'=B^{WIDTH{sub}}) plus the
//   carry from stage k-1 (stage 0 carry-in = sub). Unprocessed upper slices and the sub flag
//   are delayed alongside; finished lower slices are carried forward unchanged.
// - Latency: STAGES cycles from accepted input to out_valid (no stall). Throughput 1 beat/cycle.
// - Output register = last stage; out_* stable while out_valid & ~out_ready.
// - Saturation (SATURATE=1), applied in last stage:
//   add & cout=1 -> out_sum = {WIDTH{1}}, out_sat=1; sub & cout=0 -> out_sum = 0, out_sat=1;
//   otherwise out_sum = raw sum, out_sat=0. out_cout always the raw carry.
// - Boundaries: A+0 and A-0 exact (cout=0 / cout=1 respectively, no clamp);
//   255+1 (WIDTH=8) -> 255 sat / 0 wrap; 0-1 -> 0 sat / 255 wrap; A-A -> 0, cout=1, sat=0.
// - Simultaneous out handshake and new input in same cycle: both occur; full rate sustained.
// - STAGES=1: purely registered single-cycle adder, same handshake.
// - in_valid low: stage fills with bubble (valid=0); data regs may update, not observed.
// TESTING (WIDTH=8, STAGES=2 unless noted)
// - Reset: rst_n=0 mid-stream with 2 beats in flight -> out_valid=0 immediately, no beat emerges
//   after rst_n=1; first new beat 3+4 -> out_sum=7 after 2 cycles.
// - Add: SATURATE=1, 200+100 -> out_sum=255, out_cout=1, out_sat=1; SATURATE=0 -> out_sum=44,
//   out_cout=1, out_sat=0; 15+1 -> 16 (carry crosses segment boundary).
// - Sub: 10-20 SATURATE=1 -> 0, out_cout=0, out_sat=1; SATURATE=0 -> 246; 20-10 -> 10, cout=1.
// - Throughput: 16 back-to-back beats, out_ready=1 -> 16 results on 16 consecutive cycles,
//   first appears 2 cycles after first accept, order preserved.
// - Backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, out_sum stable,
//   no beat lost/duplicated after out_ready=1.
// - Sweep: STAGES in {1,2,4,8}, random A,B,sub vs. golden model, SATURATE in {0,1}.

Source files
------------

// File: rtl/pipelined_adder_sat_if.sv
// pipelined_adder_sat_if
//   Stream bundle for the pipelined saturating adder.
//   in_*  : operand beat (valid/ready), A, B and the subtract flag
//   out_* : result beat (valid/ready), sum, raw carry and clamp flag
//   master: upstream/downstream side (drives operands and out_ready)
//   slave : the adder itself
interface pipelined_adder_sat_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_sat;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_sat
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_sat
   );
endinterface

// File: rtl/pipelined_adder_sat.sv
// pipelined_adder_sat
//   WIDTH-bit add/subtract split into STAGES carry segments of SEG bits,
//   one registered segment per cycle. Optional unsigned saturation in the
//   last stage. Latency STAGES cycles, one beat per cycle.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : pipelined_adder_sat_if slave (operand and result streams)
module pipelined_adder_sat #(
   parameter int WIDTH    = 8,
   parameter int STAGES   = 2,
   parameter int SATURATE = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   pipelined_adder_sat_if.slave bus
);
   localparam int SEG    = WIDTH / STAGES;
   localparam bit SAT_EN = (SATURATE != 0);

   // Per-stage registers: operand A, inverted-when-sub operand B, partial
   // sum (lower segments done), segment carry-out and the sub flag.
   logic [WIDTH-1:0] a_r   [STAGES];
   logic [WIDTH-1:0] b_r   [STAGES];
   logic [WIDTH-1:0] s_r   [STAGES];
   logic             c_r   [STAGES];
   logic             sub_r [STAGES];
   logic [STAGES:1]  vld_pipe;   // vld_pipe[k+1] = valid of stage k
   logic             sat_r;
   logic             advance;

   // Whole pipeline moves as one; no bubble compression.
   assign advance       = ~vld_pipe[STAGES] | bus.out_ready;
   assign bus.in_ready  = advance;
   assign bus.out_valid = vld_pipe[STAGES];
   assign bus.out_sum   = s_r[STAGES-1];
   assign bus.out_cout  = c_r[STAGES-1];
   assign bus.out_sat   = sat_r;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic [WIDTH-1:0] a_i, b_i, s_i, s_o;
      logic             c_i, sub_i, v_i;
      logic [SEG:0]     slice;

      if (k == 0) begin : g_src
         // Subtract as A + ~B + 1: invert B once here, carry-in = sub.
         assign a_i   = bus.in_a;
         assign b_i   = bus.in_b ^ {WIDTH{bus.in_sub}};
         assign s_i   = '0;
         assign c_i   = bus.in_sub;
         assign sub_i = bus.in_sub;
         assign v_i   = bus.in_valid;
      end else begin : g_src
         assign a_i   = a_r[k-1];
         assign b_i   = b_r[k-1];
         assign s_i   = s_r[k-1];
         assign c_i   = c_r[k-1];
         assign sub_i = sub_r[k-1];
         assign v_i   = vld_pipe[k];
      end

      assign slice = {1'b0, a_i[k*SEG +: SEG]} + {1'b0, b_i[k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_i};

      always_comb begin
         s_o               = s_i;
         s_o[k*SEG +: SEG] = slice[SEG-1:0];
      end

      if (k == STAGES-1) begin : g_last
         // Add overflows with carry=1; subtract borrows with carry=0.
         logic clamp_hi, clamp_lo;
         assign clamp_hi = SAT_EN & ~sub_i &  slice[SEG];
         assign clamp_lo = SAT_EN &  sub_i & ~slice[SEG];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s_r[k]        <= '0;
               c_r[k]        <= 1'b0;
               sat_r         <= 1'b0;
               vld_pipe[k+1] <= 1'b0;
            end else if (advance) begin
               s_r[k]        <= clamp_hi ? '1 : (clamp_lo ? '0 : s_o);
               c_r[k]        <= slice[SEG];
               sat_r         <= clamp_hi | clamp_lo;
               vld_pipe[k+1] <= v_i;
            end
         end

         // Operands are fully consumed by now; slot kept only for uniform indexing.
         assign a_r[k]   = '0;
         assign b_r[k]   = '0;
         assign sub_r[k] = 1'b0;
      end else begin : g_mid
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_r[k]        <= '0;
               b_r[k]        <= '0;
               s_r[k]        <= '0;
               c_r[k]        <= 1'b0;
               sub_r[k]      <= 1'b0;
               vld_pipe[k+1] <= 1'b0;
            end else if (advance) begin
               a_r[k]        <= a_i;
               b_r[k]        <= b_i;
               s_r[k]        <= s_o;
               c_r[k]        <= slice[SEG];
               sub_r[k]      <= sub_i;
               vld_pipe[k+1] <= v_i;
            end
         end
      end
   end
endmodule

// File: tb/tb_pipelined_adder_sat.sv
// tb_pipelined_adder_sat
//   Eight adders (STAGES 1/2/4/8 x SATURATE 0/1, WIDTH 8) share one operand
//   stream. The STAGES=2 pair sees the driven out_ready and hand-computed
//   expectations; the others always accept and are checked against a model.
module tb_pipelined_adder_sat;
   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       sat;
      int         acc;
      bit         lat;
   } exp_t;

   typedef struct packed {
      logic [7:0] a, b;
      logic       s;
      logic [7:0] e1;
      logic       c;
      logic       st;
      logic [7:0] e0;
   } vec_t;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       in_vld = 1'b0, tsub = 1'b0, out_rdy = 1'b1;
   logic [7:0] ta = '0, opb = '0;
   logic [7:0] e_s1 = '0, e_s0 = '0;
   logic       e_c = 1'b0, e_sat = 1'b0;
   bit         lat_chk = 1'b0, rnd_bp = 1'b0;
   int         cyc = 0, nchk = 0, nerr = 0;
   int         qsz    [8];
   logic       rdy_v  [8];
   logic       ovld_v [8];
   logic [7:0] osum_v [8];
   logic       ocout_v[8];
   logic       osat_v [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Golden model: true unsigned arithmetic, sub as a-b+256 (bit 8 = no borrow).
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic s, input bit sat_en);
      logic [8:0] r;
      exp_t       e;
      r = s ? ({1'b0, a} - {1'b0, b} + 9'd256) : ({1'b0, a} + {1'b0, b});
      e.sum = r[7:0]; e.cout = r[8]; e.sat = 1'b0; e.acc = 0; e.lat = 1'b0;
      if (sat_en && !s && r[8])  begin e.sum = 8'hff; e.sat = 1'b1; end
      if (sat_en && s && !r[8])  begin e.sum = 8'h00; e.sat = 1'b1; end
      return e;
   endfunction

   for (genvar i = 0; i < 8; i++) begin : g_dut
      localparam int ST   = 1 << (i / 2);
      localparam int SA   = i % 2;
      localparam bit PAIR = (ST == 2);

      pipelined_adder_sat_if #(.WIDTH(8)) bus ();
      assign bus.in_valid  = in_vld;
      assign bus.in_a      = ta;
      assign bus.in_b      = opb;
      assign bus.in_sub    = tsub;
      assign bus.out_ready = PAIR ? out_rdy : 1'b1;

      pipelined_adder_sat #(.WIDTH(8), .STAGES(ST), .SATURATE(SA)) dut (
         .clk(clk), .rst_n(rst_n), .bus(bus)
      );

      assign rdy_v[i]   = bus.in_ready;
      assign ovld_v[i]  = bus.out_valid;
      assign osum_v[i]  = bus.out_sum;
      assign ocout_v[i] = bus.out_cout;
      assign osat_v[i]  = bus.out_sat;

      exp_t q[$];

      // Scoreboard: push on accept, pop/compare on output handshake.
      always @(negedge clk) begin : mon
         exp_t e, m;
         if (!rst_n) q.delete();
         else begin
            if (bus.out_valid && bus.out_ready) begin
               nchk++;
               if (q.size() == 0) begin
                  nerr++;
                  $display("FAIL extra_beat dut%0d: got sum=%0d, required no beat", i, bus.out_sum);
               end else begin
                  e = q.pop_front();
                  if (bus.out_sum !== e.sum || bus.out_cout !== e.cout || bus.out_sat !== e.sat
                      || (e.lat && (cyc - e.acc) != ST)) begin
                     nerr++;
                     $display("FAIL beat dut%0d(st=%0d,sat=%0d): got sum=%0d cout=%0b sat=%0b lat=%0d, required sum=%0d cout=%0b sat=%0b lat=%0d",
                              i, ST, SA, bus.out_sum, bus.out_cout, bus.out_sat, cyc - e.acc,
                              e.sum, e.cout, e.sat, ST);
                  end
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               m = model(bus.in_a, bus.in_b, bus.in_sub, SA != 0);
               e.sum  = PAIR ? (SA != 0 ? e_s1 : e_s0) : m.sum;
               e.cout = PAIR ? e_c : m.cout;
               e.sat  = PAIR ? (SA != 0 ? e_sat : 1'b0) : m.sat;
               e.acc  = cyc;
               e.lat  = !PAIR || lat_chk;
               q.push_back(e);
            end
         end
         qsz[i] = q.size();
      end
   end

   // Random backpressure on the STAGES=2 pair during the sweep.
   always @(posedge clk) begin
      #1;
      if (rnd_bp) out_rdy = ($urandom_range(0, 2) != 0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic set_beat(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [7:0] e1, input logic c, input logic st,
                           input logic [7:0] e0);
      ta = a; opb = b; tsub = s;
      e_s1 = e1; e_c = c; e_sat = st; e_s0 = e0;
      in_vld = 1'b1;
   endtask

   // Wait for the pair to accept the current beat; returns just after that edge.
   task automatic wait_acc();
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (rdy_v[2]) break;
         if (n == 100) begin
            nchk++; nerr++;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required 1");
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] e1, input logic c, input logic st,
                       input logic [7:0] e0);
      set_beat(a, b, s, e1, c, st, e0);
      wait_acc();
   endtask

   task automatic sendm(input logic [7:0] a, input logic [7:0] b, input logic s);
      exp_t m1, m0;
      m1 = model(a, b, s, 1'b1);
      m0 = model(a, b, s, 1'b0);
      send(a, b, s, m1.sum, m1.cout, m1.sat, m0.sum);
   endtask

   task automatic idle(input int n);
      in_vld = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   //      a       b      sub   sat1    cout  clamp  wrap
   vec_t vt[14] = '{
      '{8'd3,   8'd4,   1'b0, 8'd7,   1'b0, 1'b0, 8'd7  },
      '{8'd200, 8'd100, 1'b0, 8'd255, 1'b1, 1'b1, 8'd44 },
      '{8'd15,  8'd1,   1'b0, 8'd16,  1'b0, 1'b0, 8'd16 },
      '{8'd10,  8'd20,  1'b1, 8'd0,   1'b0, 1'b1, 8'd246},
      '{8'd20,  8'd10,  1'b1, 8'd10,  1'b1, 1'b0, 8'd10 },
      '{8'd255, 8'd1,   1'b0, 8'd255, 1'b1, 1'b1, 8'd0  },
      '{8'd0,   8'd1,   1'b1, 8'd0,   1'b0, 1'b1, 8'd255},
      '{8'd123, 8'd0,   1'b0, 8'd123, 1'b0, 1'b0, 8'd123},
      '{8'd77,  8'd0,   1'b1, 8'd77,  1'b1, 1'b0, 8'd77 },
      '{8'd99,  8'd99,  1'b1, 8'd0,   1'b1, 1'b0, 8'd0  },
      '{8'd128, 8'd128, 1'b0, 8'd255, 1'b1, 1'b1, 8'd0  },
      '{8'd255, 8'd255, 1'b1, 8'd0,   1'b1, 1'b0, 8'd0  },
      '{8'd15,  8'd16,  1'b1, 8'd0,   1'b0, 1'b1, 8'd255},
      '{8'd240, 8'd16,  1'b0, 8'd255, 1'b1, 1'b1, 8'd0  }
   };

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("rst_out_valid dut%0d", j), ovld_v[j], 0);
         chk($sformatf("rst_in_ready dut%0d", j), rdy_v[j], 1);
         chk($sformatf("rst_out_sum dut%0d", j), {osum_v[j], ocout_v[j], osat_v[j]}, 0);
      end

      // Reset with two beats in flight
      lat_chk = 1'b1;
      send(8'd1, 8'd2, 1'b0, 8'd3, 1'b0, 1'b0, 8'd3);
      send(8'd5, 8'd6, 1'b0, 8'd11, 1'b0, 1'b0, 8'd11);
      rst_n = 1'b0; in_vld = 1'b0;
      #1;
      for (int j = 0; j < 8; j++) chk($sformatf("midrst_out_valid dut%0d", j), ovld_v[j], 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(6);
      for (int j = 0; j < 8; j++) chk($sformatf("post_rst_idle dut%0d", j), {ovld_v[j], qsz[j][7:0]}, 0);

      // Directed vectors back-to-back, full rate
      for (int v = 0; v < 14; v++)
         send(vt[v].a, vt[v].b, vt[v].s, vt[v].e1, vt[v].c, vt[v].st, vt[v].e0);
      idle(10);

      // Throughput: 16 consecutive beats
      for (int v = 0; v < 16; v++) sendm(8'(v * 17), 8'(v * 29 + 3), v[0]);
      idle(10);

      // Backpressure with pipeline full
      lat_chk = 1'b0;
      out_rdy = 1'b0;
      send(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0, 8'd30);
      send(8'd250, 8'd10, 1'b1, 8'd240, 1'b1, 1'b0, 8'd240);
      set_beat(8'd100, 8'd200, 1'b0, 8'd255, 1'b1, 1'b1, 8'd44);
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready sat1", rdy_v[2], 0);
         chk("stall_in_ready sat0", rdy_v[3], 0);
         chk("stall_out_sum sat1", {ovld_v[2], osum_v[2]}, {1'b1, 8'd30});
         chk("stall_out_sum sat0", {ovld_v[3], osum_v[3]}, {1'b1, 8'd30});
      end
      @(posedge clk); #1;
      out_rdy = 1'b1;
      wait_acc();
      idle(10);

      // Sweep with random operands and backpressure
      rnd_bp = 1'b1;
      for (int v = 0; v < 200; v++) begin
         sendm(8'($urandom), 8'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      in_vld = 1'b0;
      rnd_bp = 1'b0;
      out_rdy = 1'b1;
      idle(20);
      for (int j = 0; j < 8; j++) chk($sformatf("drain_empty dut%0d", j), qsz[j], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end
endmodule
